iir_stim_seq: RTL and testbench
===============================

Name: iir_stim_seq

Overview:
- Measurement sequencer for the 5th-order direct-form IIR filter core.
- Flushes the filter, sets its feedback switch, and applies an impulse or step stimulus on x_in.
- Captures N_CAP consecutive y_out samples into a valid-qualified stream and flags overflow.
- Used for on-chip response characterisation and coefficient bring-up. Sits between a host/test register block and the filter core.

Parameters:
- FLUSH_CYC, 16: cycles filt_rst is held high before a run (minimum 1).
- LAT, 1: clock cycles from x_out change to the corresponding y_in change.
- N_CAP, 256: samples captured per run (minimum 2).
- LIMIT, 40'sh00_7FFF_FFFF: overflow threshold on |y_in| in 40-bit y_out format.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears every register.
- start  in  1  one-cycle run request; ignored unless state is IDLE.
- abort  in  1  synchronous abort of a run in progress.
- mode  in  1  0 = impulse, 1 = step; latched on start.
- fb_en  in  1  feedback switch setting for the run; latched on start.
- amp  in  64  signed stimulus amplitude, same Q format as filter x_in; latched on start.
- y_in  in  40  signed filter y_out.
- x_out  out  64  signed drive to filter x_in; registered.
- filt_rst  out  1  drive to filter reset; registered.
- switch_out  out  1  drive to filter switch; registered.
- cap_valid  out  1  cap_data/cap_idx valid this cycle.
- cap_data  out  40  signed captured y_in sample.
- cap_idx  out  $clog2(N_CAP)  sample index, 0..N_CAP-1.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at normal completion.
- ovf  out  1  sticky overflow flag for the current/last run.

Behaviour:
- Reset values (asynchronous, active-high reset): state = IDLE; all outputs 0; all counters 0.
- IDLE:
  - x_out = 0, filt_rst = 0, switch_out = 0, busy = 0.
  - start = 1: latch mode, fb_en and amp; clear ovf; load cnt = FLUSH_CYC-1; go to FLUSH.
- FLUSH:
  - filt_rst = 1, x_out = 0, switch_out = 0.
  - cnt decrements each cycle; at cnt == 0 load cnt = 1 and go to SETTLE.
  - filt_rst is therefore high exactly FLUSH_CYC cycles.
- SETTLE:
  - filt_rst = 0, switch_out = latched fb_en, x_out = 0.
  - Lasts 2 cycles, then load cnt = 0 and go to CAPT.
- CAPT:
  - cnt increments each cycle.
  - x_out = amp when cnt == 0, or for every cnt when mode = 1; otherwise 0.
  - For cnt >= LAT: y_in is sampled. On the next cycle cap_valid = 1, cap_data = that sample, cap_idx = cnt-LAT (one-cycle registered output stage).
  - Sample with cnt-LAT == N_CAP-1 is the last one: go to DONE.
  - Exactly N_CAP valid beats per run, contiguous, no backpressure.
- DONE:
  - Lasts one cycle. The final cap_valid beat and done = 1 appear in this cycle.
  - x_out = 0, switch_out keeps fb_en. Next state IDLE.
  - switch_out returns to 0 in IDLE.
- Overflow:
  - On every sampled y_in, if y_in > LIMIT or y_in < -LIMIT, set ovf.
  - ovf is sticky until the next accepted start; the run is not stopped.
  - The most negative code (-2^39) counts as overflow.
- abort:
  - In any non-IDLE state, go to IDLE on the next edge with IDLE output values.
  - No done pulse and no further cap_valid; ovf keeps its value.
  - abort in IDLE has no effect.
  - abort and start in the same IDLE cycle: start wins.
- start while busy is ignored; latched parameters do not change mid-run.
- Asynchronous reset mid-run returns to IDLE immediately with all outputs 0 (filt_rst deasserted).
- Counter cnt is wide enough for max(FLUSH_CYC, N_CAP+LAT); no wrap within a run.

Test Plan:
- Reset, then start with mode=0, amp=64'h0000000040000000, fb_en=1 -> filt_rst high 16 cycles; switch_out=1 from SETTLE on; x_out = amp for exactly one cycle then 0; 256 contiguous cap_valid beats with idx 0..255; done pulses once in the final beat cycle; busy falls the next cycle.
- Step run, mode=1, amp=64'h0000000000100000, fb_en=0, filter model with zero feedback -> x_out = amp for all 256+LAT CAPT cycles; cap_data[k] equals the model's step response; switch_out stays 0.
- Impulse run with amp=64'h7FFFFFFF00000000 driving y_in beyond LIMIT -> ovf sets on the first offending beat and stays 1 through done and IDLE. A new start clears ovf in the cycle after it is accepted.
- Assert abort at CAPT beat 10 -> cap_valid stops after beat 10 at most; no done pulse; x_out, filt_rst, switch_out and busy all 0 the next cycle; a following start runs a complete 256-beat run.
- start pulsed during FLUSH and CAPT with a different amp/mode -> ignored; the run completes with the originally latched values. Simultaneous start and abort in IDLE -> run starts.
- Asynchronous reset asserted mid-FLUSH between clock edges -> filt_rst, busy and x_out drop to 0 without waiting for a clock edge; after release the block is IDLE and accepts start.

Source files
------------

// File: rtl/iir_stim_seq.sv
// Measurement sequencer for a direct-form IIR core: flush, set feedback switch,
// apply impulse/step on x_out and capture N_CAP y_in samples with overflow flag.
module iir_stim_seq #(
    parameter int unsigned        FLUSH_CYC = 16,
    parameter int unsigned        LAT       = 1,
    parameter int unsigned        N_CAP     = 256,
    parameter logic signed [39:0] LIMIT     = 40'sh00_7FFF_FFFF,
    localparam int unsigned       IW        = $clog2(N_CAP)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 mode,
    input  logic                 fb_en,
    input  logic signed [63:0]   amp,
    input  logic signed [39:0]   y_in,
    output logic signed [63:0]   x_out,
    output logic                 filt_rst,
    output logic                 switch_out,
    output logic                 cap_valid,
    output logic signed [39:0]   cap_data,
    output logic [IW-1:0]        cap_idx,
    output logic                 busy,
    output logic                 done,
    output logic                 ovf
);

    localparam int unsigned CNT_MAX = (FLUSH_CYC > N_CAP + LAT) ? FLUSH_CYC : N_CAP + LAT;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYC - 1);
    localparam logic [CW-1:0] LAT_C      = CW'(LAT);
    localparam logic [CW-1:0] LAST_C     = CW'(N_CAP - 1 + LAT);
    localparam logic signed [39:0] NEG_LIMIT = -LIMIT;

    typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_SETTLE, S_CAPT, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 mode_q, mode_d;
    logic                 fb_q, fb_d;
    logic signed [63:0]   amp_q, amp_d;
    logic signed [63:0]   x_out_q, x_out_d;
    logic                 filt_rst_q, filt_rst_d;
    logic                 switch_q, switch_d;
    logic                 cap_valid_q, cap_valid_d;
    logic signed [39:0]   cap_data_q, cap_data_d;
    logic [IW-1:0]        cap_idx_q, cap_idx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 ovf_q, ovf_d;
    logic                 accept_c;
    logic                 sample_c;

    assign accept_c = (state_q == S_IDLE) && start;
    // A sample is taken only once the stimulus has propagated LAT cycles through the filter
    assign sample_c = (state_q == S_CAPT) && (cnt_q >= LAT_C) && !abort;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            fb_q        <= 1'b0;
            amp_q       <= '0;
            x_out_q     <= '0;
            filt_rst_q  <= 1'b0;
            switch_q    <= 1'b0;
            cap_valid_q <= 1'b0;
            cap_data_q  <= '0;
            cap_idx_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            fb_q        <= fb_d;
            amp_q       <= amp_d;
            x_out_q     <= x_out_d;
            filt_rst_q  <= filt_rst_d;
            switch_q    <= switch_d;
            cap_valid_q <= cap_valid_d;
            cap_data_q  <= cap_data_d;
            cap_idx_q   <= cap_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FLUSH;
                    cnt_d   = FLUSH_LOAD;
                end
            end
            S_FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = S_SETTLE;
                    cnt_d   = CW'(1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = S_CAPT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_CAPT: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_C) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    // Output values are computed for the upcoming state so the registers line up with it
    always_comb begin
        mode_d      = mode_q;
        fb_d        = fb_q;
        amp_d       = amp_q;
        x_out_d     = '0;
        filt_rst_d  = 1'b0;
        switch_d    = 1'b0;
        cap_valid_d = sample_c;
        cap_data_d  = cap_data_q;
        cap_idx_d   = cap_idx_q;
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        ovf_d       = ovf_q;

        if (accept_c) begin
            mode_d = mode;
            fb_d   = fb_en;
            amp_d  = amp;
            ovf_d  = 1'b0;
        end

        if ((state_d == S_CAPT) && ((cnt_d == '0) || mode_q)) begin
            x_out_d = amp_q;
        end
        filt_rst_d = (state_d == S_FLUSH);
        if ((state_d == S_SETTLE) || (state_d == S_CAPT) || (state_d == S_DONE)) begin
            switch_d = fb_q;
        end

        if (sample_c) begin
            cap_data_d = y_in;
            cap_idx_d  = IW'(cnt_q - LAT_C);
            if ((y_in > LIMIT) || (y_in < NEG_LIMIT)) begin
                ovf_d = 1'b1;
            end
        end
    end

    assign x_out      = x_out_q;
    assign filt_rst   = filt_rst_q;
    assign switch_out = switch_q;
    assign cap_valid  = cap_valid_q;
    assign cap_data   = cap_data_q;
    assign cap_idx    = cap_idx_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_iir_stim_seq.sv
// Bench for iir_stim_seq: table of runs against a saturating two-tap filter stand-in,
// scoreboard of expected capture beats, plus abort / async-reset sequences.
module tb_iir_stim_seq;

    localparam int unsigned FLUSH_CYC = 16;
    localparam int unsigned LAT       = 1;
    localparam int unsigned N_CAP     = 256;
    localparam int unsigned IW        = 8;
    localparam logic signed [39:0] LIMIT = 40'sh00_7FFF_FFFF;

    logic                clk = 1'b0;
    logic                reset;
    logic                start, abort, mode, fb_en;
    logic signed [63:0]  amp;
    logic signed [39:0]  y_in;
    logic signed [63:0]  x_out;
    logic                filt_rst, switch_out, cap_valid, busy, done, ovf;
    logic signed [39:0]  cap_data;
    logic [IW-1:0]       cap_idx;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        mode;
        logic        fb;
        logic [63:0] amp;
        logic        exp_ovf;
        logic        inject;
        logic        abort_w_start;
    } vec_t;

    vec_t vecs[9];
    logic signed [39:0] sb_q[$];

    iir_stim_seq dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
        .fb_en(fb_en), .amp(amp), .y_in(y_in), .x_out(x_out), .filt_rst(filt_rst),
        .switch_out(switch_out), .cap_valid(cap_valid), .cap_data(cap_data),
        .cap_idx(cap_idx), .busy(busy), .done(done), .ovf(ovf)
    );

    always #5 clk = ~clk;

    function automatic logic signed [39:0] sat40(input logic signed [63:0] s);
        if (s > 64'sh0000_007F_FFFF_FFFF) return 40'sh7F_FFFF_FFFF;
        if (s < -64'sh0000_0080_0000_0000) return 40'sh80_0000_0000;
        return 40'(s);
    endfunction

    // Filter stand-in: y = sat(x/2^16 + x_prev/2^17), one register of latency
    logic signed [63:0] x_d1;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_in <= '0;
            x_d1 <= '0;
        end else if (filt_rst) begin
            y_in <= '0;
            x_d1 <= '0;
        end else begin
            x_d1 <= x_out;
            y_in <= sat40((x_out >>> 16) + (x_d1 >>> 17));
        end
    end

    function automatic logic signed [39:0] exp_y(input logic [63:0] a, input logic m, input int k);
        logic signed [63:0] xk, xk1;
        xk  = (k == 0 || m) ? a : 64'd0;
        xk1 = (k >= 1 && (k == 1 || m)) ? a : 64'd0;
        return sat40((xk >>> 16) + (xk1 >>> 17));
    endfunction

    function automatic logic is_over(input logic signed [39:0] y);
        return (y > LIMIT) || (y < -LIMIT);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int   frc, xnz, beats, dones;
        logic ovf_run, seen_done, finished;
        logic signed [39:0] ey;
        frc = 0; xnz = 0; beats = 0; dones = 0;
        ovf_run = 1'b0; seen_done = 1'b0; finished = 1'b0;
        sb_q.delete();
        for (int k = 0; k < int'(N_CAP); k++) sb_q.push_back(exp_y(v.amp, v.mode, k));
        mode = v.mode; fb_en = v.fb; amp = v.amp; start = 1'b1; abort = v.abort_w_start;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("ovf_cleared_on_start", 64'(ovf), 64'd0);
        chk("busy_after_start", 64'(busy), 64'd1);
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (seen_done) begin
                chk("busy_falls_after_done", 64'(busy), 64'd0);
                chk("switch_idle", 64'(switch_out), 64'd0);
                finished = 1'b1;
                break;
            end
            if (filt_rst) frc++;
            if (x_out != 0) begin
                xnz++;
                chk("x_out_value", x_out, v.amp);
            end
            if (busy) chk("switch_out", 64'(switch_out), filt_rst ? 64'd0 : 64'(v.fb));
            if (cap_valid) begin
                if (sb_q.size() == 0) begin
                    chk("extra_beat", 64'd1, 64'd0);
                end else begin
                    ey = sb_q.pop_front();
                    chk("cap_data", 64'(cap_data), 64'(ey));
                    chk("cap_idx", 64'(cap_idx), 64'(beats));
                    ovf_run = ovf_run | is_over(ey);
                    chk("ovf_track", 64'(ovf), 64'(ovf_run));
                end
                beats++;
            end
            if (done) begin
                dones++;
                chk("done_with_last_beat", {63'd0, cap_valid}, 64'd1);
            end
            seen_done = done;
            if (v.inject && (cyc == 3 || beats == 5)) begin
                start = 1'b1; mode = ~v.mode; fb_en = ~v.fb; amp = ~v.amp;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("run_completed", 64'(finished), 64'd1);
        chk("flush_cycles", 64'(frc), 64'(FLUSH_CYC));
        chk("x_out_cycles", 64'(xnz), v.mode ? 64'(N_CAP + LAT) : 64'd1);
        chk("beat_count", 64'(beats), 64'(N_CAP));
        chk("done_count", 64'(dones), 64'd1);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        chk("ovf_final", 64'(ovf), 64'(v.exp_ovf));
        repeat (2) @(negedge clk);
        chk("ovf_sticky_idle", 64'(ovf), 64'(v.exp_ovf));
        chk("idle_outputs", {x_out[62:0], filt_rst}, 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b1, 64'h0000_0000_4000_0000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 64'h0000_0000_0010_0000, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 64'h7FFF_FFFF_0000_0000, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 64'h0000_7FFF_FFFF_0000, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 64'h0000_8000_0000_0000, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 64'hFFFF_8000_0001_0000, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 64'h0000_0000_4000_0000, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 64'h0000_0000_0010_0000, 1'b0, 1'b0, 1'b1};

        reset = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0; fb_en = 1'b0; amp = '0;
        @(negedge clk);
        chk("reset_x_out", x_out, 64'd0);
        chk("reset_ctrl", {58'd0, filt_rst, switch_out, cap_valid, busy, done, ovf}, 64'd0);
        chk("reset_cap", {16'd0, cap_data, cap_idx}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_in_idle", 64'(busy), 64'd0);

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Abort on capture beat 10
        sb_q.delete();
        mode = 1'b0; fb_en = 1'b1; amp = 64'h0000_0000_4000_0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            logic hit, bad;
            hit = 1'b0;
            for (int cyc = 0; cyc < 1000; cyc++) begin
                if (cap_valid && cap_idx == IW'(10)) begin
                    hit = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            chk("abort_reached_beat10", 64'(hit), 64'd1);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            chk("abort_x_out", x_out, 64'd0);
            chk("abort_ctrl", {60'd0, filt_rst, switch_out, busy, done}, 64'd0);
            chk("abort_cap_valid", 64'(cap_valid), 64'd0);
            bad = 1'b0;
            repeat (6) begin
                @(negedge clk);
                if (cap_valid || done || busy) bad = 1'b1;
            end
            chk("abort_quiet", 64'(bad), 64'd0);
        end
        run_vec(vecs[0]);

        // Asynchronous reset in the middle of FLUSH
        mode = 1'b1; fb_en = 1'b1; amp = 64'h0000_0000_4000_0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_flush", 64'(filt_rst), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_outputs", {x_out[62:0], filt_rst}, 64'd0);
        chk("async_reset_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_idle", {62'd0, busy, filt_rst}, 64'd0);
        run_vec(vecs[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
